// File: rtl/adder_tree_pkg.sv
// Shared types and width helpers for the adder-tree arbiter and its pipelined tree.
package adder_tree_pkg;

    typedef enum logic {IDLE, BURST} state_t;

    // Sized for the largest supported requester count (8); the top narrows it.
    localparam int ID_MAXW = 3;

    typedef struct packed {
        logic               vld;
        logic               first;
        logic               last;
        logic               trunc;
        logic [ID_MAXW-1:0] id;
    } tag_t;

    function automatic int tree_w(input int w);
        return w + 3;
    endfunction

    function automatic int acc_w(input int w, input int maxbeats);
        return w + 3 + $clog2(maxbeats);
    endfunction

    localparam int DEF_W        = 8;
    localparam int DEF_MAXBEATS = 16;
    localparam int TW           = tree_w(DEF_W);
    localparam int ACCW         = acc_w(DEF_W, DEF_MAXBEATS);

endpackage

// File: rtl/adder_tree8_pipe.sv
// Three-stage pipelined 8-lane unsigned adder tree; each stage widens by one bit.
module adder_tree8_pipe #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0][W-1:0] in_lanes,
    output logic [W+2:0]      sum
);

    logic [3:0][W:0]   s1_d, s1_q;
    logic [1:0][W+1:0] s2_d, s2_q;
    logic [W+2:0]      s3_d, s3_q;

    always_comb begin
        for (int i = 0; i < 4; i++)
            s1_d[i] = {1'b0, in_lanes[2*i]} + {1'b0, in_lanes[2*i+1]};
        for (int i = 0; i < 2; i++)
            s2_d[i] = {1'b0, s1_q[2*i]} + {1'b0, s1_q[2*i+1]};
        s3_d = {1'b0, s2_q[0]} + {1'b0, s2_q[1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign sum = s3_q;

endmodule

// File: rtl/adder_tree_arbiter.sv
// Round-robin burst arbiter sharing one pipelined adder tree; accumulates per-burst
// reductions and returns them tagged with the owning requester.
module adder_tree_arbiter
    import adder_tree_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int W        = 8,
    parameter  int MAXBEATS = 16,
    localparam int TW       = tree_w(W),
    localparam int ACCW     = acc_w(W, MAXBEATS),
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*8*W-1:0]   req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [ACCW-1:0]       rsp_sum,
    output logic                  rsp_trunc,
    output logic                  busy
);

    localparam int CW = $clog2(MAXBEATS);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [IDW-1:0]  gnt_idx, cand, sel;
    logic            gnt_found, accept, at_max, beat_last;

    // Rotating priority: first valid strictly after the last served requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(ptr_q) + i) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        sel       = (state_q == BURST) ? owner_q : gnt_idx;
        accept    = (state_q == BURST) ? req_valid[owner_q] : gnt_found;
        at_max    = (state_q == BURST) && (cnt_q == CW'(MAXBEATS - 1));
        beat_last = req_last[sel] || at_max;
        if (accept) begin
            if (beat_last) begin
                state_d = IDLE;
                ptr_d   = sel;
                cnt_d   = '0;
            end else begin
                state_d = BURST;
                owner_d = sel;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Owner keeps ready high through bubbles so it may resume at any cycle.
    always_comb begin
        req_ready = '0;
        if (!rst) begin
            if (state_q == BURST)
                req_ready[owner_q] = 1'b1;
            else if (gnt_found)
                req_ready[gnt_idx] = 1'b1;
        end
    end

    logic [7:0][W-1:0] tree_in;
    logic [TW-1:0]     tree_sum;

    assign tree_in = accept ? req_data[int'(sel)*8*W +: 8*W] : '0;

    adder_tree8_pipe #(.W(W)) u_tree (
        .clk      (clk),
        .rst      (rst),
        .in_lanes (tree_in),
        .sum      (tree_sum)
    );

    tag_t            tag_in, tag_out;
    tag_t [2:0]      tag_q, tag_d;
    logic [ACCW-1:0] acc_q, acc_d, tree_ext;
    logic            rsp_valid_q, rsp_valid_d, rsp_trunc_q, rsp_trunc_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [ACCW-1:0] rsp_sum_q, rsp_sum_d;

    assign tag_out = tag_q[2];

    always_comb begin
        tag_in       = '0;
        tag_in.vld   = accept;
        tag_in.first = accept && (state_q == IDLE);
        tag_in.last  = accept && beat_last;
        tag_in.trunc = accept && at_max && !req_last[sel];
        tag_in.id    = ID_MAXW'(sel);
        tag_d[0]     = tag_in;
        tag_d[1]     = tag_q[0];
        tag_d[2]     = tag_q[1];

        tree_ext = ACCW'(tree_sum);
        acc_d    = acc_q;
        if (tag_out.vld)
            acc_d = tag_out.first ? tree_ext : acc_q + tree_ext;

        // The result register captures the post-update accumulator of the last beat.
        rsp_valid_d = tag_out.vld && tag_out.last;
        rsp_sum_d   = rsp_valid_d ? acc_d : rsp_sum_q;
        rsp_id_d    = rsp_valid_d ? IDW'(tag_out.id) : rsp_id_q;
        rsp_trunc_d = rsp_valid_d ? tag_out.trunc : rsp_trunc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q       <= '0;
            acc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            rsp_trunc_q <= 1'b0;
        end else begin
            tag_q       <= tag_d;
            acc_q       <= acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            rsp_trunc_q <= rsp_trunc_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_trunc = rsp_trunc_q;
    assign busy      = (state_q == BURST) || tag_q[0].vld || tag_q[1].vld || tag_q[2].vld;

endmodule
